// File: rtl/key_debounce_pkg.sv
// Shared helpers for the key debouncer: time-to-cycle conversion, counter sizing
// and the channel-count limit.
package key_debounce_pkg;

  localparam int MAX_KEYS = 32;

  function automatic int us_to_cycles(input int freq_mhz, input int us);
    return freq_mhz * us;
  endfunction

  // Width able to hold 0..max_count, never narrower than one bit
  function automatic int cnt_width(input int max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One debounced key channel: 2-flop synchroniser, hold counter, level and pulse
// registers. The auto-repeat counter exists only when KEY_REPEAT_EN is defined.
module key_debounce_ch
  import key_debounce_pkg::*;
#(
  parameter int SYS_CLK_FREQ_MHZ = 10,
  parameter int HOLD_TIME_US     = 1,
  parameter int ACTIVE_HIGH      = 1,
  parameter int REPEAT_DELAY_US  = 5,
  parameter int REPEAT_PERIOD_US = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw,
  output logic level,
  output logic press,
  output logic rel,
  output logic rpt,
  output logic press_nxt
);

  localparam int HOLD = us_to_cycles(SYS_CLK_FREQ_MHZ, HOLD_TIME_US);
  localparam int HCW  = cnt_width(HOLD - 1);
  localparam int RD   = us_to_cycles(SYS_CLK_FREQ_MHZ, REPEAT_DELAY_US);
  localparam int RP   = us_to_cycles(SYS_CLK_FREQ_MHZ, REPEAT_PERIOD_US);
  localparam logic IDLE = (ACTIVE_HIGH != 0) ? 1'b0 : 1'b1;
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD - 1);

  if (HOLD < 2) begin : g_bad_hold
    $error("key_debounce_ch: hold time must be at least 2 cycles");
  end
  if (RP < 1 || RD < RP) begin : g_bad_repeat
    $error("key_debounce_ch: repeat period must be >= 1 cycle and <= repeat delay");
  end

  logic           sync_p0;
  logic           sync_p1;
  logic           p;
  logic           accept;
  logic [HCW-1:0] hold_cnt;

  // Stage 0/1: synchroniser, idles at the released level so reset never looks like a press
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= IDLE;
      sync_p1 <= IDLE;
    end else begin
      sync_p0 <= key_raw;
      sync_p1 <= sync_p0;
    end
  end

  assign p         = (ACTIVE_HIGH != 0) ? sync_p1 : ~sync_p1;
  assign accept    = (p != level) && (hold_cnt == HOLD_LAST);
  assign press_nxt = accept & p;

  // Stage 2: any sample matching the current level restarts the hold run
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt <= '0;
      level    <= 1'b0;
      press    <= 1'b0;
      rel      <= 1'b0;
    end else begin
      press <= 1'b0;
      rel   <= 1'b0;
      if (p == level) begin
        hold_cnt <= '0;
      end else if (accept) begin
        level    <= p;
        hold_cnt <= '0;
        press    <= p;
        rel      <= ~p;
      end else begin
        hold_cnt <= hold_cnt + HCW'(1);
      end
    end
  end

`ifdef KEY_REPEAT_EN
  localparam int RCW = cnt_width(RD - 1);
  localparam logic [RCW-1:0] RD_LAST = RCW'(RD - 1);

  logic [RCW-1:0] rpt_cnt;

  // After the first pulse the counter jumps back so the next one lands RP cycles later
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rpt_cnt <= '0;
      rpt     <= 1'b0;
    end else begin
      rpt <= 1'b0;
      if (!level || accept) begin
        rpt_cnt <= '0;
      end else if (rpt_cnt == RD_LAST) begin
        rpt     <= 1'b1;
        rpt_cnt <= RCW'(RD - RP);
      end else begin
        rpt_cnt <= rpt_cnt + RCW'(1);
      end
    end
  end
`else
  assign rpt = 1'b0;
`endif

endmodule

// File: rtl/multi_key_debounce.sv
// NUM_KEYS independent debounced key channels plus a registered any-press flag.
// Define KEY_REPEAT_EN to build the per-key auto-repeat counters.
module multi_key_debounce
  import key_debounce_pkg::*;
#(
  parameter int NUM_KEYS         = 4,
  parameter int SYS_CLK_FREQ_MHZ = 10,
  parameter int HOLD_TIME_US     = 1,
  parameter int ACTIVE_HIGH      = 1,
  parameter int REPEAT_DELAY_US  = 5,
  parameter int REPEAT_PERIOD_US = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_repeat,
  output logic                key_any
);

  if (NUM_KEYS < 1 || NUM_KEYS > MAX_KEYS) begin : g_bad_keys
    $error("multi_key_debounce: NUM_KEYS out of range");
  end

  logic [NUM_KEYS-1:0] press_nxt;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
    key_debounce_ch #(
      .SYS_CLK_FREQ_MHZ (SYS_CLK_FREQ_MHZ),
      .HOLD_TIME_US     (HOLD_TIME_US),
      .ACTIVE_HIGH      (ACTIVE_HIGH),
      .REPEAT_DELAY_US  (REPEAT_DELAY_US),
      .REPEAT_PERIOD_US (REPEAT_PERIOD_US)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .key_raw   (key_in[i]),
      .level     (key_level[i]),
      .press     (key_press[i]),
      .rel       (key_release[i]),
      .rpt       (key_repeat[i]),
      .press_nxt (press_nxt[i])
    );
  end

  // Registered from the channels' next-press terms so it lines up with key_press
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_any <= 1'b0;
    end else begin
      key_any <= |press_nxt;
    end
  end

endmodule

// File: tb/tb_multi_key_debounce.sv
// Bench for multi_key_debounce: segment table, hand-written corner sequences and
// randomized traffic against a sliding-window reference model.
`timescale 1ns/1ps
module tb_multi_key_debounce;

  localparam int NK   = 4;
  localparam int FREQ = 10;
  localparam int HOLD = FREQ * 1;
  localparam int RD   = FREQ * 5;
  localparam int RP   = FREQ * 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [NK-1:0] key_in = '0;
  logic [NK-1:0] key_in_n = '1;
  logic [NK-1:0] key_level, key_press, key_release, key_repeat;
  logic          key_any;
  logic [NK-1:0] key_level_n, key_press_n, key_release_n, key_repeat_n;
  logic          key_any_n;

  always #5 clk = ~clk;

  multi_key_debounce #(.NUM_KEYS(NK), .ACTIVE_HIGH(1)) dut (
    .clk(clk), .rst(rst), .key_in(key_in), .key_level(key_level),
    .key_press(key_press), .key_release(key_release),
    .key_repeat(key_repeat), .key_any(key_any));

  multi_key_debounce #(.NUM_KEYS(NK), .ACTIVE_HIGH(0)) dut_n (
    .clk(clk), .rst(rst), .key_in(key_in_n), .key_level(key_level_n),
    .key_press(key_press_n), .key_release(key_release_n),
    .key_repeat(key_repeat_n), .key_any(key_any_n));

  int vectors = 0;
  int miscompares = 0;

  // Reference model: a level flips once the last HOLD synchronised samples all disagree with it
  logic [NK-1:0] dly_q[$];
  logic [NK-1:0] win_q[$];
  logic [NK-1:0] m_level, m_press, m_rel, m_rpt;
  logic          m_any;
  int            ecount;
  int            press_edge[NK];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    dly_q.delete();
    dly_q.push_back('0);
    dly_q.push_back('0);
    win_q.delete();
    m_level = '0; m_press = '0; m_rel = '0; m_rpt = '0; m_any = 1'b0;
    ecount = 0;
    for (int b = 0; b < NK; b++) press_edge[b] = 0;
  endtask

  task automatic model_edge();
    logic [NK-1:0] p, old;
    bit all_diff;
    int t;
    if (rst) begin
      model_reset();
      return;
    end
    ecount++;
    dly_q.push_back(key_in);
    p = dly_q.pop_front();
    win_q.push_back(p);
    if (win_q.size() > HOLD) void'(win_q.pop_front());
    old = m_level;
    m_press = '0; m_rel = '0; m_rpt = '0;
    for (int b = 0; b < NK; b++) begin
      all_diff = (win_q.size() == HOLD);
      foreach (win_q[j]) if (win_q[j][b] == old[b]) all_diff = 0;
      if (all_diff) begin
        m_level[b] = ~old[b];
        if (!old[b]) begin
          m_press[b] = 1'b1;
          press_edge[b] = ecount;
        end else begin
          m_rel[b] = 1'b1;
        end
      end else if (old[b]) begin
        t = ecount - press_edge[b];
        if (t >= RD && ((t - RD) % RP) == 0) m_rpt[b] = 1'b1;
      end
    end
    m_any = |m_press;
`ifndef KEY_REPEAT_EN
    m_rpt = '0;
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("m_level",   key_level,   m_level);
    check("m_press",   key_press,   m_press);
    check("m_release", key_release, m_rel);
    check("m_repeat",  key_repeat,  m_rpt);
    check("m_any",     key_any,     m_any);
  endtask

  task automatic assert_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check("rst_level",     key_level,     0);
    check("rst_press",     key_press,     0);
    check("rst_release",   key_release,   0);
    check("rst_repeat",    key_repeat,    0);
    check("rst_any",       key_any,       0);
    check("rst_n_level",   key_level_n,   0);
    check("rst_n_press",   key_press_n,   0);
    check("rst_n_release", key_release_n, 0);
    check("rst_n_repeat",  key_repeat_n,  0);
    check("rst_n_any",     key_any_n,     0);
  endtask

  typedef struct {
    logic [NK-1:0] key;
    int            cycles;
    int            at;
    logic [NK-1:0] press;
    logic [NK-1:0] rel;
    logic [NK-1:0] level;
  } seg_t;

  seg_t segs[13];

  initial begin
    int got;
    logic exp_r;

    segs[0]  = '{4'b0001, 30, 12, 4'b0001, 4'b0000, 4'b0001};
    segs[1]  = '{4'b0000, 30, 12, 4'b0000, 4'b0001, 4'b0000};
    segs[2]  = '{4'b0010,  3,  0, 4'b0000, 4'b0000, 4'b0000};
    segs[3]  = '{4'b0000,  3,  0, 4'b0000, 4'b0000, 4'b0000};
    segs[4]  = '{4'b0010,  3,  0, 4'b0000, 4'b0000, 4'b0000};
    segs[5]  = '{4'b0000,  3,  0, 4'b0000, 4'b0000, 4'b0000};
    segs[6]  = '{4'b0010,  3,  0, 4'b0000, 4'b0000, 4'b0000};
    segs[7]  = '{4'b0000,  3,  0, 4'b0000, 4'b0000, 4'b0000};
    segs[8]  = '{4'b0010,  3,  0, 4'b0000, 4'b0000, 4'b0000};
    segs[9]  = '{4'b0000,  3,  0, 4'b0000, 4'b0000, 4'b0000};
    segs[10] = '{4'b0010, 30, 12, 4'b0010, 4'b0000, 4'b0010};
    segs[11] = '{4'b1110, 30, 12, 4'b1100, 4'b0000, 4'b1110};
    segs[12] = '{4'b0000, 30, 12, 4'b0000, 4'b1110, 4'b0000};

    #2;
    assert_reset();
    repeat (3) step();
    rst = 1'b0;

    for (int s = 0; s < 13; s++) begin
      key_in = segs[s].key;
      for (int i = 1; i <= segs[s].cycles; i++) begin
        step();
        check("seg_press",   key_press,   (i == segs[s].at) ? segs[s].press : '0);
        check("seg_release", key_release, (i == segs[s].at) ? segs[s].rel   : '0);
        check("seg_any",     key_any,     (i == segs[s].at) && (|segs[s].press));
      end
      check("seg_level", key_level, segs[s].level);
    end

    // Reset while key 0 is five counts into its hold run
    key_in = 4'b0001;
    repeat (7) step();
    assert_reset();
    repeat (3) step();
    rst = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      step();
      check("rst_fresh_press", key_press[0], i == 12);
      check("n_idle_press",    key_press_n,   0);
      check("n_idle_release",  key_release_n, 0);
    end

    // Active-low instance: press then release key 0
    key_in_n = 4'b1110;
    for (int i = 1; i <= 14; i++) begin
      step();
      check("n_press",  key_press_n,  (i == 12) ? 4'b0001 : 4'b0000);
      check("n_any",    key_any_n,    i == 12);
      check("n_repeat", key_repeat_n, 0);
    end
    check("n_level_on", key_level_n, 4'b0001);
    key_in_n = '1;
    for (int i = 1; i <= 14; i++) begin
      step();
      check("n_release", key_release_n, (i == 12) ? 4'b0001 : 4'b0000);
      check("n_press_q", key_press_n,   0);
    end
    check("n_level_off", key_level_n, 0);

    // Auto-repeat on a long hold of key 0
    key_in = '0;
    repeat (14) step();
    key_in = 4'b0001;
    got = 0;
    for (int i = 0; i < 20 && got == 0; i++) begin
      step();
      if (key_press[0]) got = 1;
    end
    check("rep_press_seen", got, 1);
    for (int t = 1; t <= 120; t++) begin
      step();
`ifdef KEY_REPEAT_EN
      exp_r = (t == 50 || t == 70 || t == 90 || t == 110);
`else
      exp_r = 1'b0;
`endif
      check("repeat", key_repeat[0], exp_r);
    end

    // Randomized traffic with alternating bounce-heavy and long-hold phases
    for (int c = 0; c < 1500; c++) begin
      for (int b = 0; b < NK; b++)
        if ($urandom_range(0, ((c / 300) % 2 == 1) ? 60 : 8) == 0) key_in[b] = ~key_in[b];
      if (c == 700) begin
        assert_reset();
        step();
        rst = 1'b0;
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multi_key_debounce.md
Name: multi_key_debounce

Overview:
- Parametrised, multi-channel successor to the single-key press debouncer.
- Synchronises and debounces NUM_KEYS asynchronous button inputs in both directions (press and release).
- Per key, outputs a stable level plus single-cycle press and release pulses; optional auto-repeat pulse for held keys.
- Sits between board button pins and the CPU control / step logic.

Parameters:
- NUM_KEYS, 4, number of independent key channels (1..32).
- SYS_CLK_FREQ_MHZ, 10, system clock frequency in MHz.
- HOLD_TIME_US, 1, stable time required to accept a level change, in µs (20000 on hardware).
- ACTIVE_HIGH, 1, 1 = pressed key reads 1; 0 = pressed key reads 0.
- REPEAT_DELAY_US, 5, hold time before the first repeat pulse (auto-repeat only).
- REPEAT_PERIOD_US, 2, interval between subsequent repeat pulses (auto-repeat only).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous active-high reset.
- key_in  in  NUM_KEYS  raw asynchronous button inputs.
- key_level  out  NUM_KEYS  debounced state, 1 = pressed (polarity-normalised).
- key_press  out  NUM_KEYS  one-cycle pulse when a press is accepted.
- key_release  out  NUM_KEYS  one-cycle pulse when a release is accepted.
- key_repeat  out  NUM_KEYS  one-cycle auto-repeat pulse (0 unless feature enabled).
- key_any  out  1  OR of key_press bits, registered with them.

Behaviour:
- HOLD = SYS_CLK_FREQ_MHZ*HOLD_TIME_US cycles, required >= 2 (elaboration error otherwise).
- Counter width = $clog2(max count + 1).
- Reset: every output, counter and key_level is 0. Synchroniser flops reset to the inactive level (~ACTIVE_HIGH), so a reset never yields a spurious press.
- Sync: 2-flop synchroniser per bit, then polarity-normalised to p (1 = pressed).
- Per channel, each edge:
  - If p == key_level: cnt <= 0.
  - Else if cnt == HOLD-1: key_level <= p, cnt <= 0, key_press <= p, key_release <= ~p.
  - Else: cnt <= cnt+1.
- key_press / key_release are 0 on all other cycles.
- Any bounce sample equal to key_level clears cnt; the full HOLD run restarts.
- Latency: a clean input change sampled at edge k produces key_level and the pulse registered at edge k+HOLD+1, visible one cycle later. That is HOLD+2 edges total (12 at defaults).
- Channels are fully independent. Several press/release pulses may assert in the same cycle; key_any ORs them.
- Mid-operation reset clears all state immediately. A key held through reset deassertion is accepted as a fresh press HOLD+2 edges after reset release.
- No counter wrap: cnt never exceeds HOLD-1.

Optional Feature:
- Macro: KEY_REPEAT_EN.
- Defined:
  - Per-channel repeat counter, RD = SYS_CLK_FREQ_MHZ*REPEAT_DELAY_US, RP = SYS_CLK_FREQ_MHZ*REPEAT_PERIOD_US.
  - Counter clears while key_level == 0 and on the key_press cycle.
  - While key_level == 1 it counts. The first key_repeat pulse fires RD cycles after key_press, then one every RP cycles until release.
  - Release clears the counter in the same cycle key_release asserts; no repeat pulse coincides with key_release.
- Undefined: no repeat counters synthesised; key_repeat tied to 0.

Decomposition:
- Package key_debounce_pkg holds:
  - Function us_to_cycles(freq_mhz, us).
  - Max channel-count constant (32).
  - Counter-width helper function.
- Sub-module key_debounce_ch: one channel containing the synchroniser, hold counter, level register, pulse regs and optional repeat counter.
- multi_key_debounce instantiates key_debounce_ch NUM_KEYS times via generate, plus the key_any OR register.

Test Plan:
- Clean press: key_in[0] 0→1 held 30 cycles.
  → key_press[0] pulses once, 12 edges after the change; key_level[0]=1; no other bits move.
- Bounce: key_in[1] toggles every 3 cycles for 20 cycles, then holds 1.
  → Single key_press[1], exactly 12 edges after the final transition.
- Release: after a stable press, key_in[0] 1→0.
  → key_release[0] pulses once after 12 edges; key_level[0]=0; key_press stays 0.
- Simultaneous: key_in[2] and key_in[3] rise on the same edge.
  → key_press[2] and key_press[3] assert on the same cycle; key_any=1 for exactly that cycle.
- Reset mid-count: assert rst at cnt=5 with key_in[0]=1, release it.
  → All outputs 0 during reset; key_press[0] 12 edges after deassertion. Repeat with ACTIVE_HIGH=0 and inputs idle at 1 → no pulses.
- With KEY_REPEAT_EN: hold key 0 for 120 cycles after the press.
  → key_repeat[0] at +50, +70, +90, +110 cycles after key_press. Without the macro, key_repeat stays 0.
